// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct3/funct7 into the ALU operation code and registers it
// with its operands behind a valid/ready handshake. Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     illegal
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQUAL = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL   = OPCODE_LENGTH'(4'b1111);

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_ill;
  logic                     accept;

  always_comb begin
    dec_op  = OP_ILL;
    dec_ill = 1'b1;
    case (ALUOp)
      2'b00: begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
      end
      2'b01: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_op  = OP_EQUAL;
          dec_ill = 1'b0;
        end
      end
      2'b10: begin
        // Only funct3 000 may use funct7 0100000 (SUB); everything else needs funct7 = 0.
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_op  = OP_ADD;
              dec_ill = 1'b0;
            end else if (funct7 == 7'b0100000) begin
              dec_op  = OP_SUB;
              dec_ill = 1'b0;
            end
          end
          3'b111: if (funct7 == 7'b0000000) begin dec_op = OP_AND; dec_ill = 1'b0; end
          3'b110: if (funct7 == 7'b0000000) begin dec_op = OP_OR;  dec_ill = 1'b0; end
          3'b100: if (funct7 == 7'b0000000) begin dec_op = OP_XOR; dec_ill = 1'b0; end
          default: ;
        endcase
      end
      default: begin
        case (funct3)
          3'b000: begin dec_op = OP_ADD; dec_ill = 1'b0; end
          3'b111: begin dec_op = OP_AND; dec_ill = 1'b0; end
          3'b110: begin dec_op = OP_OR;  dec_ill = 1'b0; end
          3'b100: begin dec_op = OP_XOR; dec_ill = 1'b0; end
          default: ;
        endcase
      end
    endcase
  end

  assign accept = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
  logic                     skid_valid;
  logic [OPCODE_LENGTH-1:0] skid_op;
  logic [DATA_WIDTH-1:0]    skid_a;
  logic [DATA_WIDTH-1:0]    skid_b;
  logic                     skid_ill;

  assign in_ready = !reset && !skid_valid;

  // Output register refills from skid first so ordering stays FIFO; a stalled accept parks in skid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      Operation  <= '0;
      SrcA       <= '0;
      SrcB       <= '0;
      illegal    <= 1'b0;
      skid_valid <= 1'b0;
      skid_op    <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
      skid_ill   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        Operation  <= skid_op;
        SrcA       <= skid_a;
        SrcB       <= skid_b;
        illegal    <= skid_ill;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        Operation <= dec_op;
        SrcA      <= src_a;
        SrcB      <= src_b;
        illegal   <= dec_ill;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_op    <= dec_op;
      skid_a     <= src_a;
      skid_b     <= src_b;
      skid_ill   <= dec_ill;
    end
  end
`else
  assign in_ready = !reset && (!out_valid || out_ready);

  // Single register: loads whenever it is empty or being drained this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      Operation <= '0;
      SrcA      <= '0;
      SrcB      <= '0;
      illegal   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= accept;
      if (accept) begin
        Operation <= dec_op;
        SrcA      <= src_a;
        SrcB      <= src_b;
        illegal   <= dec_ill;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: table-driven decode vectors plus stall/reset sequences.
// Works for both the default build and ALU_ISSUE_SKID_EN.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [1:0]  aluOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        outValid;
  logic        outReady;
  logic [3:0]  operation;
  logic [31:0] srcAOut;
  logic [31:0] srcBOut;
  logic        illegalOut;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  expOp;
    logic        expIll;
  } vec_t;

  vec_t vecs[14];

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .ALUOp(aluOp), .funct3(funct3), .funct7(funct7), .src_a(srcA), .src_b(srcB),
    .out_valid(outValid), .out_ready(outReady), .Operation(operation),
    .SrcA(srcAOut), .SrcB(srcBOut), .illegal(illegalOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    inValid = v;
    aluOp   = op;
    funct3  = f3;
    funct7  = f7;
    srcA    = a;
    srcB    = b;
  endtask

  task automatic checkIssued(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic ill);
    checkOutput({name, ".valid"}, {31'b0, outValid}, 32'd1);
    checkOutput({name, ".op"}, {28'b0, operation}, {28'b0, op});
    checkOutput({name, ".a"}, srcAOut, a);
    checkOutput({name, ".b"}, srcBOut, b);
    checkOutput({name, ".ill"}, {31'b0, illegalOut}, {31'b0, ill});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{2'b10, 3'b000, 7'b0000000, 32'd5,  32'd3,  4'b0010, 1'b0};
    vecs[1]  = '{2'b10, 3'b000, 7'b0100000, 32'd9,  32'd4,  4'b0110, 1'b0};
    vecs[2]  = '{2'b01, 3'b001, 7'b0000000, 32'd7,  32'd7,  4'b1000, 1'b0};
    vecs[3]  = '{2'b10, 3'b010, 7'b0000000, 32'd1,  32'd2,  4'b1111, 1'b1};
    vecs[4]  = '{2'b10, 3'b000, 7'b0000000, 32'd11, 32'd12, 4'b0010, 1'b0};
    vecs[5]  = '{2'b00, 3'b101, 7'b1111111, 32'h100, 32'h8, 4'b0010, 1'b0};
    vecs[6]  = '{2'b01, 3'b000, 7'b0000000, 32'd3,  32'd3,  4'b1000, 1'b0};
    vecs[7]  = '{2'b01, 3'b100, 7'b0000000, 32'd3,  32'd4,  4'b1111, 1'b1};
    vecs[8]  = '{2'b10, 3'b111, 7'b0000000, 32'hF0, 32'h3C, 4'b0000, 1'b0};
    vecs[9]  = '{2'b10, 3'b110, 7'b0100000, 32'hF0, 32'h3C, 4'b1111, 1'b1};
    vecs[10] = '{2'b10, 3'b100, 7'b0000000, 32'hAA, 32'h55, 4'b0011, 1'b0};
    vecs[11] = '{2'b10, 3'b000, 7'b0000001, 32'd2,  32'd2,  4'b1111, 1'b1};
    vecs[12] = '{2'b11, 3'b111, 7'b0100000, 32'hFF, 32'h0F, 4'b0000, 1'b0};
    vecs[13] = '{2'b11, 3'b001, 7'b0000000, 32'd6,  32'd1,  4'b1111, 1'b1};

    reset    = 1'b1;
    outReady = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst.in_ready", {31'b0, inReady}, 32'd0);
    checkOutput("rst.out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("rst.op", {28'b0, operation}, 32'd0);
    checkOutput("rst.ill", {31'b0, illegalOut}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rel.in_ready", {31'b0, inReady}, 32'd1);

    // Back-to-back decode vectors with EX always ready.
    outReady = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
      #1;
      checkOutput($sformatf("vec%0d.in_ready", i), {31'b0, inReady}, 32'd1);
      @(posedge clk);
      #1;
      checkIssued($sformatf("vec%0d", i), vecs[i].expOp, vecs[i].a, vecs[i].b, vecs[i].expIll);
    end
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drain.out_valid", {31'b0, outValid}, 32'd0);

    // Stall: X (SUB) then Y (XOR) with EX not ready; both must issue in order.
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(1'b1, 2'b10, 3'b000, 7'b0100000, 32'd20, 32'd8);
    @(posedge clk);
    #1;
    checkIssued("stallX", 4'b0110, 32'd20, 32'd8, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 3'b100, 7'b0, 32'd33, 32'd44);
    #1;
`ifdef ALU_ISSUE_SKID_EN
    checkOutput("stallY.in_ready", {31'b0, inReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    #1;
    checkOutput("skidfull.in_ready", {31'b0, inReady}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkIssued("holdX", 4'b0110, 32'd20, 32'd8, 1'b0);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkIssued("relY", 4'b0011, 32'd33, 32'd44, 1'b0);
    checkOutput("relY.in_ready", {31'b0, inReady}, 32'd1);
`else
    checkOutput("stallY.in_ready", {31'b0, inReady}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkIssued("holdX", 4'b0110, 32'd20, 32'd8, 1'b0);
    @(negedge clk);
    outReady = 1'b1;
    #1;
    checkOutput("rel.in_ready2", {31'b0, inReady}, 32'd1);
    @(posedge clk);
    #1;
    checkIssued("relY", 4'b0011, 32'd33, 32'd44, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
`endif
    @(posedge clk);
    #1;
    checkOutput("afterY.out_valid", {31'b0, outValid}, 32'd0);

    // Reset while stalled with ops buffered discards everything.
    @(negedge clk);
    outReady = 1'b0;
    applyStimulus(1'b1, 2'b00, 3'b000, 7'b0, 32'd1, 32'd1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 3'b110, 7'b0, 32'd2, 32'd2);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("midrst.out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("midrst.in_ready", {31'b0, inReady}, 32'd0);
    checkOutput("midrst.a", srcAOut, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("postrst.in_ready", {31'b0, inReady}, 32'd1);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst.out_valid", {31'b0, outValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
